// File: rtl/axis_write_data.sv
// Write-data engine: packs WIDTH_RATIO stream words per AXI beat, buffers beats in a FIFO,
// drives the W channel with per-burst wlast and counts B responses until the transfer completes.
module axis_write_data #(
    parameter int unsigned BUF_AWIDTH     = 9,
    parameter int unsigned CFG_DWIDTH     = 32,
    parameter int unsigned WIDTH_RATIO    = 1,
    parameter int unsigned AXI_LEN_WIDTH  = 8,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CFG_DWIDTH-1:0]       cfg_length,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [DATA_WIDTH-1:0]       data,
    input  logic                        valid,
    output logic                        ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wlast,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    input  logic                        axi_bvalid,
    output logic                        axi_bready
);

    localparam int unsigned StrbW     = AXI_DATA_WIDTH / 8;
    localparam int unsigned LaneStrbW = DATA_WIDTH / 8;
    localparam int unsigned RatioLog  = $clog2(WIDTH_RATIO);
    localparam int unsigned Depth     = 2 ** BUF_AWIDTH;
    localparam int unsigned FifoW     = AXI_DATA_WIDTH + StrbW + 1;

    typedef enum logic [1:0] {StIdle, StActive, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    cfg_ready_q, cfg_ready_d;
    logic [CFG_DWIDTH-1:0]   len_q, beats_q, bursts_q;
    logic [CFG_DWIDTH-1:0]   words_q, pushed_q, beats_done_q, resp_q;
    logic [CFG_DWIDTH-1:0]   beats_calc, bursts_calc, lane;
    logic [AXI_DATA_WIDTH-1:0] pack_q, push_data;
    logic [StrbW-1:0]        push_strb;
    logic                    push_last;
    logic                    cfg_hs, word_hs, word_done, push, pop, fifo_full;
    logic                    w_hs, b_hs;

    logic [FifoW-1:0]        mem [Depth];
    logic [BUF_AWIDTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [BUF_AWIDTH:0]     count_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [StrbW-1:0]        wstrb_q;
    logic                    wlast_q, wvalid_q;

    // Ceiling divisions by powers of two, written so they cannot overflow.
    assign beats_calc  = (cfg_length >> RatioLog)
                       + CFG_DWIDTH'(|(cfg_length & CFG_DWIDTH'(WIDTH_RATIO - 1)));
    assign bursts_calc = (beats_calc >> AXI_LEN_WIDTH)
                       + CFG_DWIDTH'(|beats_calc[AXI_LEN_WIDTH-1:0]);

    assign cfg_hs    = cfg_valid && cfg_ready_q;
    assign lane      = words_q & CFG_DWIDTH'(WIDTH_RATIO - 1);
    assign pop       = (count_q != '0) && (!wvalid_q || axi_wready);
    assign fifo_full = count_q == (BUF_AWIDTH + 1)'(Depth);
    assign ready     = (state_q == StActive) && (words_q < len_q) && (!fifo_full || pop);
    assign word_hs   = valid && ready;
    assign word_done = (lane == CFG_DWIDTH'(WIDTH_RATIO - 1)) || (words_q + 1'b1 == len_q);
    assign push      = word_hs && word_done;
    assign push_last = (pushed_q[AXI_LEN_WIDTH-1:0] == '1) || (pushed_q + 1'b1 == beats_q);
    assign w_hs      = wvalid_q && axi_wready;
    assign axi_bready = (state_q == StActive) || (state_q == StResp);
    assign b_hs      = axi_bvalid && axi_bready;

    assign cfg_ready  = cfg_ready_q;
    assign axi_wdata  = wdata_q;
    assign axi_wstrb  = wstrb_q;
    assign axi_wlast  = wlast_q;
    assign axi_wvalid = wvalid_q;

    // Incoming word lands in its lane; lanes above it stay zero for a partial final beat.
    always_comb begin
        push_data = pack_q;
        push_strb = '0;
        for (int i = 0; i < WIDTH_RATIO; i++) begin
            if (CFG_DWIDTH'(i) == lane) push_data[i*DATA_WIDTH +: DATA_WIDTH] = data;
            if (CFG_DWIDTH'(i) <= lane) push_strb[i*LaneStrbW +: LaneStrbW] = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cfg_hs && (cfg_length != '0)) state_d = StActive;
            end
            StActive: begin
                if ((words_q == len_q) && (beats_done_q == beats_q)) begin
                    state_d = (resp_q >= bursts_q) ? StIdle : StResp;
                end
            end
            StResp: begin
                if (resp_q >= bursts_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        cfg_ready_d = (state_d == StIdle) && !cfg_hs;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            cfg_ready_q  <= 1'b0;
            len_q        <= '0;
            beats_q      <= '0;
            bursts_q     <= '0;
            words_q      <= '0;
            pushed_q     <= '0;
            beats_done_q <= '0;
            resp_q       <= '0;
            pack_q       <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            if (cfg_hs) begin
                len_q        <= cfg_length;
                beats_q      <= beats_calc;
                bursts_q     <= bursts_calc;
                words_q      <= '0;
                pushed_q     <= '0;
                beats_done_q <= '0;
                resp_q       <= '0;
            end else begin
                if (word_hs) words_q <= words_q + 1'b1;
                if (push) pushed_q <= pushed_q + 1'b1;
                if (w_hs) beats_done_q <= beats_done_q + 1'b1;
                if (b_hs) resp_q <= resp_q + 1'b1;
            end
            if (word_hs) pack_q <= push ? '0 : push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {push_last, push_strb, push_data};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            wlast_q  <= 1'b0;
            wvalid_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            // Output register refills only when empty or being consumed, so W stays stable.
            if (pop) begin
                {wlast_q, wstrb_q, wdata_q} <= mem[rd_ptr_q];
                wvalid_q <= 1'b1;
            end else if (axi_wready) begin
                wvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_write_data.sv
// Randomized scoreboard bench for axis_write_data at WIDTH_RATIO=4 (32-bit stream, 128-bit AXI).
module tb_axis_write_data;

    localparam int Ratio    = 4;
    localparam int BurstLen = 256;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cfg_length;
    logic         cfg_valid, cfg_ready;
    logic [31:0]  data;
    logic         valid, ready;
    logic [127:0] axi_wdata;
    logic [15:0]  axi_wstrb;
    logic         axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;

    int    checks = 0;
    int    failures = 0;
    int    beat_cnt = 0;
    int    wr_mode = 1;
    beat_t exp_q[$];
    longint mL, mB, m_taken, m_bidx;
    logic [31:0] m_cur[$];

    axis_write_data #(
        .BUF_AWIDTH(9), .CFG_DWIDTH(32), .WIDTH_RATIO(Ratio), .AXI_LEN_WIDTH(8),
        .AXI_DATA_WIDTH(128), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .cfg_length(cfg_length), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .data(data), .valid(valid), .ready(ready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(string name);
        check(name, {cfg_ready, ready, axi_wvalid, axi_wlast, axi_bready,
                     |axi_wdata, |axi_wstrb}, '0);
    endtask

    function automatic void model_cfg(longint l);
        mL = l;
        mB = (l + Ratio - 1) / Ratio;
        m_taken = 0;
        m_bidx = 0;
        m_cur.delete();
    endfunction

    // A beat closes after Ratio words or at word L; lanes fill from the LSB upwards.
    function automatic void model_accept(logic [31:0] w);
        beat_t b;
        m_cur.push_back(w);
        m_taken++;
        if (m_cur.size() == Ratio || m_taken == mL) begin
            b.data = '0;
            b.strb = '0;
            foreach (m_cur[k]) begin
                b.data[k*32 +: 32] = m_cur[k];
                b.strb[k*4 +: 4] = 4'hF;
            end
            b.last = (m_bidx % BurstLen == BurstLen - 1) || (m_bidx == mB - 1);
            exp_q.push_back(b);
            m_bidx++;
            m_cur.delete();
        end
    endfunction

    // Monitor: checks every W handshake against the scoreboard and W stability under stall.
    initial begin
        logic [127:0] hold_data;
        logic [15:0]  hold_strb;
        logic         hold_last;
        bit           stalled;
        beat_t        e;
        stalled = 0;
        hold_data = '0;
        hold_strb = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("w_stable", {axi_wvalid, axi_wlast, axi_wstrb, axi_wdata} ==
                                      {1'b1, hold_last, hold_strb, hold_data}, 1);
                end
                if (axi_wvalid && axi_wready) begin
                    beat_cnt++;
                    stalled = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", axi_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("wdata", axi_wdata, e.data);
                        check("wstrb", axi_wstrb, e.strb);
                        check("wlast", axi_wlast, e.last);
                    end
                end else if (axi_wvalid) begin
                    stalled = 1;
                    hold_data = axi_wdata;
                    hold_strb = axi_wstrb;
                    hold_last = axi_wlast;
                end else begin
                    stalled = 0;
                end
            end
        end
    end

    initial begin
        axi_wready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wr_mode)
                0:       axi_wready = 1'b0;
                1:       axi_wready = 1'b1;
                default: axi_wready = ($urandom_range(3) != 0);
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic do_cfg(longint l);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!cfg_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cfg_ready_wait", cfg_ready, 1);
        cfg_length = l[31:0];
        cfg_valid = 1'b1;
        model_cfg(l);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("cfg_ready_after_hs", cfg_ready, 0);
    endtask

    task automatic send_words(int n, int pct, int max_cycles, int stop_beat, bit seq,
                              output int sent);
        int cyc;
        logic [31:0] w;
        cyc = 0;
        sent = 0;
        w = seq ? 32'd0 : $urandom;
        while (sent < n && cyc < max_cycles && !(stop_beat > 0 && beat_cnt >= stop_beat)) begin
            @(posedge clk); #1;
            valid = ($urandom_range(99) < 32'(pct));
            data = w;
            @(negedge clk);
            if (valid && ready) begin
                model_accept(w);
                sent++;
                w = seq ? 32'(sent) : $urandom;
            end
            cyc++;
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && m_bidx == mB) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, (exp_q.size() == 0) && (m_bidx == mB), 1);
    endtask

    task automatic pulse_b();
        @(posedge clk); #1;
        axi_bvalid = 1'b1;
        @(posedge clk); #1;
        axi_bvalid = 1'b0;
    endtask

    task automatic finish_b(string name);
        pulse_b();
        check({name, "_busy"}, cfg_ready, 0);
        @(posedge clk); #1;
        check({name, "_idle"}, cfg_ready, 1);
    endtask

    task automatic basic_pack(string name);
        int sent;
        do_cfg(8);
        send_words(8, 100, 100, 0, 1, sent);
        check({name, "_sent"}, sent, 8);
        check({name, "_lat_gap"}, axi_wvalid, 0);
        @(posedge clk); #1;
        check({name, "_lat_wvalid"}, axi_wvalid, 1);
        check({name, "_lat_wlast"}, axi_wlast, 1);
        finish_b(name);
    endtask

    initial begin
        int sent, sent2;
        bit bad;
        rst = 1'b0;
        cfg_valid = 1'b0;
        cfg_length = '0;
        valid = 1'b0;
        data = '0;
        axi_bvalid = 1'b0;
        model_cfg(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_hold");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset("reset_first_cycle");
        @(posedge clk); #1;
        check("cfg_ready_rise", cfg_ready, 1);

        basic_pack("basic");

        // Partial final beat; words beyond L must be refused.
        do_cfg(6);
        send_words(6, 100, 100, 0, 0, sent);
        check("partial_sent", sent, 6);
        valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (ready) bad = 1;
        end
        @(posedge clk); #1;
        valid = 1'b0;
        check("ready_after_L", bad, 0);
        wait_done("partial_beats");
        finish_b("partial");

        do_cfg(0);
        @(negedge clk);
        check("zero_ready", ready, 0);
        check("zero_wvalid", axi_wvalid, 0);
        @(posedge clk); #1;
        check("zero_cfg_ready", cfg_ready, 1);

        // Two bursts: one response is not enough to complete.
        wr_mode = 2;
        do_cfg(1100);
        send_words(1100, 75, 10000, 0, 0, sent);
        check("multi_sent", sent, 1100);
        wait_done("multi_beats");
        pulse_b();
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (cfg_ready) bad = 1;
        end
        check("multi_resp_wait", bad, 0);
        finish_b("multi");

        // Back-pressure: FIFO fills, stream stalls, then everything drains in order.
        wr_mode = 0;
        do_cfg(4000);
        send_words(4000, 100, 2200, 0, 0, sent);
        check("bp_fill", (sent >= 2048) && (sent <= 2055), 1);
        @(negedge clk);
        check("bp_ready_low", ready, 0);
        wr_mode = 2;
        send_words(4000 - sent, 90, 20000, 0, 0, sent2);
        check("bp_total", sent + sent2, 4000);
        wait_done("bp_beats");
        repeat (3) pulse_b();
        finish_b("bp");

        // Reset in the middle of a long transfer, then a clean transfer.
        wr_mode = 1;
        do_cfg(1100);
        send_words(1100, 100, 5000, beat_cnt + 100, 0, sent);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset("reset_mid");
        model_cfg(0);
        @(posedge clk); #1;
        rst = 1'b1;
        basic_pack("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
